// File: rtl/alu_iter_mod_pkg.sv
// Shared encodings for the iterative ALU: operation codes and controller states.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_XOR = 3'b010,
    ALU_NOR = 3'b011,
    ALU_ADD = 3'b100,
    ALU_SUB = 3'b101,
    ALU_MUL = 3'b110,
    ALU_DIV = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_iter_mod_if.sv
// Operand/result handshake bundle between the ALU and its producer/consumer.
interface alu_iter_mod_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       alu_select;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] alu_out_hi;
  logic             carry;
  logic             zero;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output in_valid, a, b, alu_select, out_ready,
    input  in_ready, out_valid, alu_out, alu_out_hi, carry, zero, overflow, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, alu_select, out_ready,
    output in_ready, out_valid, alu_out, alu_out_hi, carry, zero, overflow, div_by_zero
  );
endinterface

// File: rtl/alu_iter_mod_core.sv
// One-bit-per-cycle datapath: right-shift shift-add multiply and restoring divide.
// The *_nxt outputs show the state after the step in progress so the top can latch the final one.
module alu_iter_core #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [WIDTH-1:0] lo_nxt_o,
  output logic [WIDTH-1:0] hi_nxt_o
);
  logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, opb_q, opb_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH-1:0] rem_diff, step_acc, step_sh;

  // Multiply: {acc, sh} shifts right with sh holding the multiplier.
  // Divide: sh holds the dividend, quotient bits shift in from the right.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
    rem_sh   = {acc_q, sh_q[WIDTH-1]};
    rem_diff = rem_sh[WIDTH-1:0] - opb_q;
    if (div_q) begin
      if (rem_sh >= {1'b0, opb_q}) begin
        step_acc = rem_diff;
        step_sh  = {sh_q[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = rem_sh[WIDTH-1:0];
        step_sh  = {sh_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_acc = mul_sum[WIDTH:1];
      step_sh  = {mul_sum[0], sh_q[WIDTH-1:1]};
    end

    acc_d = acc_q;
    sh_d  = sh_q;
    opb_d = opb_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (start_i) begin
      acc_d = '0;
      sh_d  = is_div_i ? a_i : b_i;
      opb_d = is_div_i ? b_i : a_i;
      div_d = is_div_i;
      cnt_d = CNT_W'(WIDTH);
    end else if (step_i) begin
      acc_d = step_acc;
      sh_d  = step_sh;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      sh_q  <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      opb_q <= opb_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign lo_nxt_o = step_sh;
  assign hi_nxt_o = step_acc;
endmodule

// File: rtl/alu_iter_mod.sv
// Handshaked ALU: controller, single-cycle ops and flag generation around the iterative core.
// state  | meaning
// S_IDLE | waiting for in_valid, in_ready high
// S_BUSY | MUL/DIV iterating, one bit per cycle
// S_DONE | result held with out_valid until out_ready
module alu_iter_mod
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  alu_iter_mod_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  alu_op_e          op_q, op_d, sel;
  logic [WIDTH-1:0] out_q, out_d, hi_q, hi_d;
  logic             carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d, dbz_q, dbz_d;
  logic [WIDTH:0]   add_sum, sub_diff;
  logic [WIDTH-1:0] core_lo, core_hi;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign sel      = alu_op_e'(bus.alu_select);
  assign accept   = bus.in_valid && (state_q == S_IDLE);
  assign add_sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_diff = {1'b0, bus.a} - {1'b0, bus.b};

  alu_iter_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .start_i  (accept),
    .step_i   (state_q == S_BUSY),
    .is_div_i (sel == ALU_DIV),
    .a_i      (bus.a),
    .b_i      (bus.b),
    .cnt_o    (cnt),
    .lo_nxt_o (core_lo),
    .hi_nxt_o (core_hi)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    out_d   = out_q;
    hi_d    = hi_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = sel;
          state_d = S_DONE;
          hi_d    = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          dbz_d   = 1'b0;
          case (sel)
            ALU_AND: out_d = bus.a & bus.b;
            ALU_OR:  out_d = bus.a | bus.b;
            ALU_XOR: out_d = bus.a ^ bus.b;
            ALU_NOR: out_d = ~(bus.a | bus.b);
            ALU_ADD: begin
              out_d   = add_sum[WIDTH-1:0];
              carry_d = add_sum[WIDTH];
              ovf_d   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            ALU_SUB: begin
              out_d   = sub_diff[WIDTH-1:0];
              carry_d = sub_diff[WIDTH];
              ovf_d   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            ALU_MUL: state_d = S_BUSY;
            ALU_DIV: begin
              if (bus.b == '0) begin
                out_d = '1;
                hi_d  = bus.a;
                dbz_d = 1'b1;
              end else begin
                state_d = S_BUSY;
              end
            end
            default: state_d = S_DONE;
          endcase
        end
      end
      S_BUSY: begin
        if (cnt == CNT_W'(1)) begin
          state_d = S_DONE;
          out_d   = core_lo;
          hi_d    = core_hi;
          carry_d = (op_q == ALU_MUL) && (|core_hi);
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    zero_d = (out_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= ALU_AND;
      out_q   <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.alu_out     = out_q;
  assign bus.alu_out_hi  = hi_q;
  assign bus.carry       = carry_q;
  assign bus.zero        = zero_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dbz_q;
endmodule
